// File: rtl/uart_rx_engine.sv
// uart_rx_engine: UART receiver with mid-bit sampling, parity/stop checking and PicoBlaze status flags.
// Optional macro RX_NOISE_FILTER_EN enables 2-of-3 majority sampling of the serial line.
module uart_rx_engine #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic [3:0] baud_val,
    input  logic       bit78,
    input  logic       parity_en,
    input  logic       parity_oe,
    input  logic       rd_data,
    input  logic       int_ack,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic [7:0] status
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
    state_t state, next_state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [17:0] cnt;
    logic [3:0] baud_q;
    logic [7:0] shift_q;
    logic [2:0] nbits;
    logic line, smp, expire, clr;
    logic b78_q, pen_q, poe_q, par_acc, par_err_q, stop_q, done;
    logic overrun, parity_err, framing_err;

    function automatic logic [17:0] bit_clks(input logic [3:0] b);
        case (b)
            4'd0:    return 18'd166667;
            4'd1:    return 18'd41667;
            4'd2:    return 18'd20833;
            4'd3:    return 18'd10417;
            4'd4:    return 18'd5208;
            4'd5:    return 18'd2604;
            4'd6:    return 18'd1302;
            4'd7:    return 18'd868;
            4'd9:    return 18'd217;
            4'd10:   return 18'd109;
            4'd11:   return 18'd54;
            default: return 18'd434;
        endcase
    endfunction

    assign line   = sync_q[SYNC_STAGES-1];
    assign expire = cnt == 18'd0;
    assign clr    = rd_data || int_ack;
    assign status = {2'b00, overrun, parity_err, framing_err, 2'b00, rx_rdy};

`ifdef RX_NOISE_FILTER_EN
    logic [1:0] hist;
    always_ff @(posedge clk or negedge reset)
        if (!reset) hist <= 2'b11;
        else        hist <= {hist[0], line};
    assign smp = (line & hist[0]) | (line & hist[1]) | (hist[0] & hist[1]);
`else
    assign smp = line;
`endif

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= next_state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (!line) next_state = START;
            START:     if (expire) next_state = smp ? IDLE : DATA;
            DATA:      if (expire && nbits == (b78_q ? 3'd7 : 3'd6)) next_state = pen_q ? PARITY : STOP;
            PARITY:    if (expire) next_state = STOP;
            STOP:      if (expire) next_state = smp ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (line) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q      <= '1;
            cnt         <= '0;
            baud_q      <= '0;
            b78_q       <= 1'b0;
            pen_q       <= 1'b0;
            poe_q       <= 1'b0;
            shift_q     <= '0;
            nbits       <= '0;
            par_acc     <= 1'b0;
            par_err_q   <= 1'b0;
            stop_q      <= 1'b1;
            done        <= 1'b0;
            rx_data     <= '0;
            rx_rdy      <= 1'b0;
            overrun     <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
            done   <= state == STOP && expire;
            // IDLE keeps tracking the switches so the frame starts with the settings live at start detect
            if (state == IDLE) begin
                cnt    <= (bit_clks(baud_val) >> 1) - 18'd1;
                baud_q <= baud_val;
                b78_q  <= bit78;
                pen_q  <= parity_en;
                poe_q  <= parity_oe;
            end else begin
                cnt <= expire ? bit_clks(baud_q) - 18'd1 : cnt - 18'd1;
            end
            if (state == START) begin
                nbits     <= '0;
                par_acc   <= 1'b0;
                par_err_q <= 1'b0;
            end
            if (state == DATA && expire) begin
                shift_q <= {smp, shift_q[7:1]};
                nbits   <= nbits + 3'd1;
                par_acc <= par_acc ^ smp;
            end
            if (state == PARITY && expire) par_err_q <= par_acc ^ smp ^ poe_q;
            if (state == STOP && expire) stop_q <= smp;
            // Completion beats a same-cycle clear; the old byte then counts as consumed
            if (done) begin
                rx_data     <= b78_q ? shift_q : {1'b0, shift_q[7:1]};
                rx_rdy      <= 1'b1;
                framing_err <= !stop_q;
                parity_err  <= par_err_q;
                overrun     <= rx_rdy && !clr;
            end else if (clr) begin
                rx_rdy      <= 1'b0;
                framing_err <= 1'b0;
                parity_err  <= 1'b0;
                overrun     <= 1'b0;
            end
        end
    end
endmodule
